// File: rtl/word_unpacker.sv
// word_unpacker: splits one WORD_W word per handshake into NBYTES bytes,
// LSB first, on a byte-wide valid/ready stream.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   en            enable; low freezes state and masks both handshakes
//   in_data       word to unpack
//   in_nbytes     bytes to emit (1..NBYTES; 0 or >NBYTES means NBYTES)
//   in_valid      word-side valid
//   in_ready      word-side ready
//   out_data      current byte
//   out_valid     byte-side valid
//   out_ready     byte-side ready
//   out_last      final byte of the current word
//   busy          a word is held (SEND)
//   out_parity    XOR of out_data (only with WORD_UNPACKER_PARITY_EN)
//
// Build option: define WORD_UNPACKER_PARITY_EN to add out_parity.
module word_unpacker #(
  parameter  int WORD_W = 32,
  parameter  int BYTE_W = 8,
  localparam int NBYTES = WORD_W / BYTE_W,
  localparam int CNT_W  = $clog2(NBYTES) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [WORD_W-1:0] in_data,
  input  logic [CNT_W-1:0]  in_nbytes,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy
`ifdef WORD_UNPACKER_PARITY_EN
  ,
  output logic              out_parity
`endif
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t              state_q;
  logic [WORD_W-1:0]   sh_q;
  logic [CNT_W-1:0]    rem_q;
  logic                last_q;

  logic                send;
  logic                take_in;
  logic                take_out;
  logic [CNT_W-1:0]    nb_d;
  logic [WORD_W-1:0]   sh_d;

  assign send      = (state_q == SEND);
  assign out_valid = en && send;
  assign take_out  = out_valid && out_ready;

  // In SEND, a new word may only be taken in the same cycle the
  // final byte leaves, which gives back-to-back words with no bubble.
  assign in_ready = en && !rst &&
                    (!send || (out_ready && last_q));
  assign take_in  = in_valid && in_ready;

  always_comb begin
    nb_d = in_nbytes;
    if (in_nbytes == '0 || in_nbytes > CNT_W'(NBYTES))
      nb_d = CNT_W'(NBYTES);
  end

  // The word is kept in a right-shift register, so the current byte
  // is always the low slice and holds in IDLE after the last byte.
  assign sh_d = sh_q >> BYTE_W;

  assign out_data = sh_q[BYTE_W-1:0];
  assign out_last = last_q;
  assign busy     = send;

`ifdef WORD_UNPACKER_PARITY_EN
  logic par_q;
  assign out_parity = par_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      rem_q   <= '0;
      last_q  <= 1'b0;
`ifdef WORD_UNPACKER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else if (take_in) begin
      state_q <= SEND;
      sh_q    <= in_data;
      rem_q   <= nb_d;
      last_q  <= (nb_d == CNT_W'(1));
`ifdef WORD_UNPACKER_PARITY_EN
      par_q   <= ^in_data[BYTE_W-1:0];
`endif
    end else if (take_out) begin
      unique case (last_q)
        1'b1: begin
          state_q <= IDLE;
          last_q  <= 1'b0;
        end
        default: begin
          sh_q   <= sh_d;
          rem_q  <= rem_q - CNT_W'(1);
          last_q <= (rem_q == CNT_W'(2));
`ifdef WORD_UNPACKER_PARITY_EN
          par_q  <= ^sh_d[BYTE_W-1:0];
`endif
        end
      endcase
    end
  end

endmodule
